// File: rtl/riscv_regfile_wb_arbiter.sv
// riscv_regfile_wb_arbiter
// Shares the single integer regfile write port between two writeback sources:
// the ALU/EX result (port A, priority) and the LSU load result (port B).
// A starvation counter forces a B grant after STARVE_MAX consecutive A grants
// while B is waiting. A pending-write scoreboard answers rs1/rs2 RAW queries.
// Optional feature macro: WBARB_BYPASS_EN. When it is defined, the registered
// write is forwarded to the issue stage and clears busy one cycle early.
`timescale 1ns/1ps
module riscv_regfile_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic            i_wbarb_clk,
  input  logic            i_wbarb_rst,
  input  logic            i_wbarb_a_valid,
  output logic            o_wbarb_a_ready,
  input  logic [4:0]      i_wbarb_a_addr,
  input  logic [XLEN-1:0] i_wbarb_a_data,
  input  logic            i_wbarb_b_valid,
  output logic            o_wbarb_b_ready,
  input  logic [4:0]      i_wbarb_b_addr,
  input  logic [XLEN-1:0] i_wbarb_b_data,
  input  logic            i_wbarb_issue_valid,
  input  logic [4:0]      i_wbarb_issue_rd,
  input  logic [4:0]      i_wbarb_rs1_addr,
  input  logic [4:0]      i_wbarb_rs2_addr,
  output logic            o_wbarb_rs1_busy,
  output logic            o_wbarb_rs2_busy,
  output logic [31:0]     o_wbarb_pending,
  output logic            o_wbarb_wen,
  output logic [4:0]      o_wbarb_wr_addr,
  output logic [XLEN-1:0] o_wbarb_wr_data,
  output logic            o_wbarb_rs1_fwd_valid,
  output logic [XLEN-1:0] o_wbarb_rs1_fwd_data,
  output logic            o_wbarb_rs2_fwd_valid,
  output logic [XLEN-1:0] o_wbarb_rs2_fwd_data
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]      starve_cnt;
  logic            grant_a;
  logic            grant_b;
  logic            xfer;
  logic [4:0]      sel_addr;
  logic [XLEN-1:0] sel_data;
  logic            wen;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [31:0]     pending;
  logic [31:0]     clr_mask;
  logic [31:0]     set_mask;
  logic [31:0]     pending_next;
  logic            rs1_fwd;
  logic            rs2_fwd;

  // Fixed-priority grant with starvation override; B wins only when A is idle or B has waited too long
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (i_wbarb_b_valid && (!i_wbarb_a_valid || (starve_cnt == STARVE_LIM))) begin
      grant_b = 1'b1;
    end else if (i_wbarb_a_valid) begin
      grant_a = 1'b1;
    end else begin
      grant_a = 1'b0;
      grant_b = 1'b0;
    end
  end

  assign o_wbarb_a_ready = grant_a;
  assign o_wbarb_b_ready = grant_b;

  // Mux the granted request toward the write register
  always_comb begin
    xfer     = grant_a | grant_b;
    sel_addr = 5'd0;
    sel_data = '0;
    if (grant_b) begin
      sel_addr = i_wbarb_b_addr;
      sel_data = i_wbarb_b_data;
    end else if (grant_a) begin
      sel_addr = i_wbarb_a_addr;
      sel_data = i_wbarb_a_data;
    end else begin
      sel_addr = 5'd0;
      sel_data = '0;
    end
  end

  // Starvation counter: counts A grants that leave a valid B waiting, saturating at the limit
  always_ff @(posedge i_wbarb_clk or posedge i_wbarb_rst) begin
    if (i_wbarb_rst) begin
      starve_cnt <= 4'd0;
    end else if (grant_b || !i_wbarb_b_valid) begin
      starve_cnt <= 4'd0;
    end else if (grant_a && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= starve_cnt;
    end
  end

  // Registered regfile write; x0 transfers are swallowed and leave addr/data untouched
  always_ff @(posedge i_wbarb_clk or posedge i_wbarb_rst) begin
    if (i_wbarb_rst) begin
      wen     <= 1'b0;
      wr_addr <= 5'd0;
      wr_data <= '0;
    end else if (xfer && (sel_addr != 5'd0)) begin
      wen     <= 1'b1;
      wr_addr <= sel_addr;
      wr_data <= sel_data;
    end else begin
      wen     <= 1'b0;
      wr_addr <= wr_addr;
      wr_data <= wr_data;
    end
  end

  // Scoreboard update: clear on the regfile capture edge, then set on issue so a same-edge set wins
  always_comb begin
    clr_mask     = wen ? (32'd1 << wr_addr) : 32'd0;
    set_mask     = (i_wbarb_issue_valid && (i_wbarb_issue_rd != 5'd0)) ? (32'd1 << i_wbarb_issue_rd) : 32'd0;
    pending_next = ((pending & ~clr_mask) | set_mask) & ~32'd1;
  end

  // Pending-write vector register
  always_ff @(posedge i_wbarb_clk or posedge i_wbarb_rst) begin
    if (i_wbarb_rst) begin
      pending <= 32'd0;
    end else begin
      pending <= pending_next;
    end
  end

  assign o_wbarb_pending = pending;
  assign o_wbarb_wen     = wen;
  assign o_wbarb_wr_addr = wr_addr;
  assign o_wbarb_wr_data = wr_data;

`ifdef WBARB_BYPASS_EN
  assign rs1_fwd = wen && (wr_addr == i_wbarb_rs1_addr) && (i_wbarb_rs1_addr != 5'd0);
  assign rs2_fwd = wen && (wr_addr == i_wbarb_rs2_addr) && (i_wbarb_rs2_addr != 5'd0);
  assign o_wbarb_rs1_fwd_data = wr_data;
  assign o_wbarb_rs2_fwd_data = wr_data;
`else
  assign rs1_fwd = 1'b0;
  assign rs2_fwd = 1'b0;
  assign o_wbarb_rs1_fwd_data = '0;
  assign o_wbarb_rs2_fwd_data = '0;
`endif

  assign o_wbarb_rs1_fwd_valid = rs1_fwd;
  assign o_wbarb_rs2_fwd_valid = rs2_fwd;
  // A forwarded operand no longer has to wait for the regfile
  assign o_wbarb_rs1_busy = pending[i_wbarb_rs1_addr] & ~rs1_fwd;
  assign o_wbarb_rs2_busy = pending[i_wbarb_rs2_addr] & ~rs2_fwd;

endmodule
